pixel_pack_fifo: RTL
====================

// Module: pixel_pack_fifo
// PURPOSE
//  Downstream stage of data_processor. Takes its 32-bit signed result stream (out_pixel/out_valid),
//  saturates each result to 8 bits, packs 4 pixels per 32-bit word and tracks row/frame position.
//  Buffers the words in a synchronous FIFO and presents them on a valid/ready stream to the host side.
//  data_processor has no backpressure. Overflow drops whole words and the loss is counted.
// PARAMETERS
//  IMG_WIDTH   32  pixels per row (>=1); row ends flush a partial word
//  IMG_HEIGHT  32  rows per frame (>=1)
//  FIFO_DEPTH  16  FIFO entries, power of 2, >=2
// PORTS
//  clk        in   1   system clock (same domain as data_processor)
//  resetn     in   1   synchronous, active-low reset
//  sync_clr   in   1   soft clear; same effect as reset, one cycle
//  in_valid   in   1   connects to data_processor out_valid
//  in_pixel   in   32  connects to data_processor out_pixel, two's complement
//  out_valid  out  1   FIFO head valid (= !empty)
//  out_ready  in   1   consumer accepts head when out_valid&&out_ready
//  out_data   out  32  packed pixels; lane0 = bits[7:0] = earliest pixel
//  out_keep   out  4   lane valid mask; 4'b1111 except partial end-of-row words
//  out_last   out  1   word holds last pixel of a row
//  out_eof    out  1   word holds last pixel of a frame (out_last also 1)
//  fifo_level out  $clog2(FIFO_DEPTH)+1  current entry count
//  overflow   out  1   sticky; set on any dropped word
//  drop_cnt   out  16  dropped-word count, saturates at 16'hFFFF
//  frame_cnt  out  16  completed frames (eof words generated, dropped or not), wraps
//  stat_min   out  8   see CONFIGURATION
//  stat_max   out  8   see CONFIGURATION
// BEHAVIOUR
//  Reset/sync_clr: all outputs 0. Counters, packer and FIFO are emptied. Clear has priority over same-cycle input.
//  Saturation: in_pixel<0 gives 8'h00. in_pixel>255 gives 8'hFF. Otherwise in_pixel[7:0].
//  Position: col counts 0..IMG_WIDTH-1 and row counts 0..IMG_HEIGHT-1.
//   Each in_valid advances col. col wraps to 0 and row increments at end of row. row wraps to 0 at end of frame.
//  Packer: lane index = col%4 within the row; a row always starts at lane 0.
//   A word is emitted when lane 3 fills or when col==IMG_WIDTH-1, whichever comes first.
//   Unfilled lanes are 0 and their keep bits are 0. keep is contiguous from lane 0.
//  Emit: the word is written to the FIFO on the same clk edge that samples the completing pixel.
//   With the FIFO empty, out_valid=1 in the following cycle (1-cycle latency).
//  FIFO entry = {eof,last,keep,data}, 38 bits, first-word-fall-through. Head is stable while out_valid&&!out_ready.
//  Push is accepted if !full, or if full and a pop happens in the same cycle.
//   Otherwise the word is dropped: overflow<=1 and drop_cnt increments.
//   Position counters advance regardless, so frame alignment survives a drop.
//  Pop with FIFO empty is ignored. Simultaneous push+pop leaves fifo_level unchanged.
//  out_ready low indefinitely is legal: the FIFO fills, then words are dropped.
//  in_valid is valid in any cycle, including back-to-back every cycle.
//  frame_cnt increments on the eof word event.
// CONFIGURATION
//  PIX_STATS_EN defined:
//   Per-frame running min/max of the saturated pixels.
//   On the eof pixel, stat_min/stat_max are updated to that frame's values (that pixel included); the running values then restart.
//   Reset values: stat_min=0, stat_max=0.
//  PIX_STATS_EN undefined: stat_min and stat_max are tied to 8'h00 and no stats logic is built.
// TESTING
//  1 IMG_WIDTH=8, IMG_HEIGHT=2, out_ready=1; pixels 1..16 back-to-back
//    -> 4 words: 32'h04030201, 32'h08070605 (last), 32'h0C0B0A09, 32'h100F0E0D (last, eof).
//    All keep=4'hF; frame_cnt=1.
//  2 Saturation: in_pixel -5, 300, 255, 0 -> word 32'h00FFFF00.
//  3 IMG_WIDTH=6 row of 10..15 -> words 32'h0D0C0B0A keep=F, then 32'h00000F0E keep=4'b0011 last=1.
//  4 FIFO_DEPTH=4, out_ready=0, push 6 words -> fifo_level=4, overflow=1, drop_cnt=2.
//    Then out_ready=1 -> the first 4 words drain in order.
//  5 FIFO full with push and pop in the same cycle -> no drop; fifo_level stays 4.
//  6 sync_clr mid-row, then a new frame starting with pixel 7 -> first word lane0=8'h07.
//    All flags are 0 after the clear.
//    With PIX_STATS_EN, a frame with min 3 and max 200 -> stat_min=3, stat_max=200 after eof.

Source files
------------

// File: rtl/pixel_pack_fifo.sv
// Saturates a 32-bit signed pixel stream to 8 bits, packs 4 pixels per word with row/frame
// markers and buffers the words in a FWFT FIFO. Optional per-frame min/max under PIX_STATS_EN.
module pixel_pack_fifo #(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          sync_clr,
    input  logic                          in_valid,
    input  logic [31:0]                   in_pixel,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_data,
    output logic [3:0]                    out_keep,
    output logic                          out_last,
    output logic                          out_eof,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [15:0]                   drop_cnt,
    output logic [15:0]                   frame_cnt,
    output logic [7:0]                    stat_min,
    output logic [7:0]                    stat_max
);
    localparam int LANES = 4;
    localparam int CW    = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic                        eof;
        logic                        last;
        logic [LANES-1:0]            keep;
        logic [LANES-1:0][7:0]       data;
    } entry_t;

    logic                    clr;
    logic [7:0]              pix_sat;
    logic [CW-1:0]           col_q;
    logic [RW-1:0]           row_q;
    logic [1:0]              lane_q;
    logic [LANES-1:0][7:0]   pack_q;
    logic                    end_row, end_frame, emit;
    entry_t                  wentry, head;
    entry_t                  mem [FIFO_DEPTH];
    logic [AW-1:0]           wptr_q, rptr_q;
    logic [AW:0]             cnt_q, cnt_d;
    logic                    empty, full, push, pop, drop;
    logic                    overflow_q;
    logic [15:0]             drop_cnt_q, frame_cnt_q;

    assign clr = !resetn || sync_clr;

    always_comb begin
        pix_sat = in_pixel[7:0];
        if (in_pixel[31])
            pix_sat = 8'h00;
        else if (|in_pixel[30:8])
            pix_sat = 8'hFF;
    end

    assign end_row   = (col_q == CW'(IMG_WIDTH - 1));
    assign end_frame = end_row && (row_q == RW'(IMG_HEIGHT - 1));
    assign emit      = in_valid && ((lane_q == 2'd3) || end_row);

    // The completing pixel bypasses pack_q so the word lands in the FIFO on its own edge.
    always_comb begin
        wentry      = '0;
        wentry.eof  = end_frame;
        wentry.last = end_row;
        for (int i = 0; i < LANES; i++) begin
            if (2'(i) < lane_q) begin
                wentry.data[i] = pack_q[i];
                wentry.keep[i] = 1'b1;
            end else if (2'(i) == lane_q) begin
                wentry.data[i] = pix_sat;
                wentry.keep[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            col_q  <= '0;
            row_q  <= '0;
            lane_q <= '0;
            pack_q <= '0;
        end else if (in_valid) begin
            pack_q[lane_q] <= pix_sat;
            if (end_row) begin
                col_q  <= '0;
                lane_q <= '0;
                row_q  <= end_frame ? '0 : row_q + RW'(1);
            end else begin
                col_q  <= col_q + CW'(1);
                lane_q <= lane_q + 2'd1;
            end
        end
    end

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign pop   = !empty && out_ready;
    assign push  = emit && (!full || pop);
    assign drop  = emit && !push;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + (AW+1)'(1);
        else if (pop && !push)
            cnt_d = cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push && !clr)
            mem[wptr_q] <= wentry;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push)
                wptr_q <= wptr_q + AW'(1);
            if (pop)
                rptr_q <= rptr_q + AW'(1);
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF)
                    drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (emit && end_frame)
                frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    // Head fields are masked while empty so stale RAM contents never leak out.
    assign head       = empty ? '0 : mem[rptr_q];
    assign out_valid  = !empty;
    assign out_data   = head.data;
    assign out_keep   = head.keep;
    assign out_last   = head.last;
    assign out_eof    = head.eof;
    assign fifo_level = cnt_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;
    assign frame_cnt  = frame_cnt_q;

`ifdef PIX_STATS_EN
    logic [7:0] run_min_q, run_max_q, stat_min_q, stat_max_q, fmin, fmax;

    assign fmin = (pix_sat < run_min_q) ? pix_sat : run_min_q;
    assign fmax = (pix_sat > run_max_q) ? pix_sat : run_max_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            run_min_q  <= 8'hFF;
            run_max_q  <= 8'h00;
            stat_min_q <= 8'h00;
            stat_max_q <= 8'h00;
        end else if (in_valid) begin
            if (end_frame) begin
                stat_min_q <= fmin;
                stat_max_q <= fmax;
                run_min_q  <= 8'hFF;
                run_max_q  <= 8'h00;
            end else begin
                run_min_q <= fmin;
                run_max_q <= fmax;
            end
        end
    end

    assign stat_min = stat_min_q;
    assign stat_max = stat_max_q;
`else
    assign stat_min = 8'h00;
    assign stat_max = 8'h00;
`endif

endmodule
